// File: rtl/ram_burst_reader_pkg.sv
// ram_burst_reader_pkg: shared state encoding and buffer sizing for the burst reader
package ram_burst_reader_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int BUF_DEPTH = 4;
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
endpackage

// File: rtl/ram_rd_buf.sv
// ram_rd_buf: small synchronous FIFO holding returned read beats with their last flag
module ram_rd_buf
    import ram_burst_reader_pkg::*;
#(
    parameter int W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [W-1:0]     i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [W-1:0]     o_data,
    output logic [CNT_W-1:0] o_count
);
    localparam int PW = $clog2(BUF_DEPTH);
    logic [W-1:0]     r_mem [BUF_DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;
    assign w_pop   = i_pop && (r_count != '0);
    assign o_valid = r_count != '0;
    assign o_data  = (r_count == '0) ? '0 : r_mem[r_rd];
    assign o_count = r_count;
    // storage: contents need no reset, emptiness is tracked by the count
    always_ff @(posedge clk)
        if (i_push) r_mem[r_wr] <= i_data;
    // pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_pop);
        end
    end
endmodule

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: reads a wrapping address burst from a synchronous RAM into a ready/valid stream
module ram_burst_reader
    import ram_burst_reader_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W:0]   i_len,
    output logic [ADDR_W-1:0] o_ram_addr,
    input  logic [DATA_W-1:0] i_ram_dout,
    output logic              o_m_valid,
    input  logic              i_m_ready,
    output logic [DATA_W-1:0] o_m_data,
    output logic              o_m_last,
    output logic              o_busy,
    output logic              o_done
);
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);
    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [ADDR_W:0]   r_rem;
    logic              r_v1;
    logic              r_l1;
    logic              r_v2;
    logic              r_l2;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W:0]   w_len;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_occ;
    logic              w_issue;
    logic              w_pop;
    assign w_len   = (i_len > MAX_LEN) ? MAX_LEN : i_len;
    assign w_occ   = w_count + CNT_W'(r_v1) + CNT_W'(r_v2);
    assign w_issue = (r_state == RUN) && (w_occ < CNT_W'(BUF_DEPTH));
    assign w_pop   = o_m_valid && i_m_ready;
    assign o_ram_addr = r_ram_addr;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    // control FSM plus the two-stage read pipeline (address register, then RAM latency)
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_ram_addr <= '0;
            r_rem      <= '0;
            r_v1       <= 1'b0;
            r_l1       <= 1'b0;
            r_v2       <= 1'b0;
            r_l2       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_v1   <= w_issue;
            r_l1   <= w_issue && (r_rem == ONE);
            r_v2   <= r_v1;
            r_l2   <= r_l1;
            if (w_issue) begin
                r_ram_addr <= r_addr;
                r_addr     <= r_addr + 1'b1;
                r_rem      <= r_rem - ONE;
            end
            case (r_state)
                IDLE: if (i_start) begin
                    if (w_len == '0) r_done <= 1'b1;
                    else begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_addr  <= i_base_addr;
                        r_rem   <= w_len;
                    end
                end
                RUN: if (w_issue && r_rem == ONE) r_state <= DRAIN;
                DRAIN: if (w_pop && o_m_last) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    ram_rd_buf #(.W(DATA_W + 1)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_v2),
        .i_data  ({r_l2, i_ram_dout}),
        .i_pop   (w_pop),
        .o_valid (o_m_valid),
        .o_data  ({o_m_last, o_m_data}),
        .o_count (w_count)
    );
endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader: directed and randomized bursts checked against a queue-based beat model
module tb_ram_burst_reader;
    localparam int DW = 16;
    localparam int AW = 4;
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_start = 1'b0;
    logic          i_m_ready = 1'b0;
    logic [AW-1:0] i_base_addr = '0;
    logic [AW:0]   i_len = '0;
    logic [AW-1:0] o_ram_addr;
    logic [DW-1:0] ram_dout = '0;
    logic [DW-1:0] o_m_data;
    logic          o_m_valid;
    logic          o_m_last;
    logic          o_busy;
    logic          o_done;
    logic [DW-1:0] mem [16];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // synchronous RAM: data for the sampled address appears one edge later
    always @(posedge clk) ram_dout <= mem[o_ram_addr];

    ram_burst_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_len       (i_len),
        .o_ram_addr  (o_ram_addr),
        .i_ram_dout  (ram_dout),
        .o_m_valid   (o_m_valid),
        .i_m_ready   (i_m_ready),
        .o_m_data    (o_m_data),
        .o_m_last    (o_m_last),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_valid", o_m_valid, 0);
        chk("rst_last", o_m_last, 0);
        chk("rst_data", o_m_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_addr", o_ram_addr, 0);
    endtask

    // mode: 0 ready always, 1 ready toggling, 2 ready random; tim checks exact beat cycles;
    // poke re-pulses start mid-burst; abort_n>0 resets after that many beats
    task automatic burst(input logic [3:0] base, input logic [4:0] len, input int mode,
                         input bit tim, input bit poke, input int abort_n);
        logic [16:0] exp_q[$];
        logic [16:0] pd = '0;
        int n = (len > 16) ? 16 : int'(len);
        int nb = 0;
        int cyc = 0;
        int lx = -1;
        bit pv = 0;
        bit pr = 0;
        bit fin = 0;
        for (int i = 0; i < n; i++) exp_q.push_back({1'(i == n - 1), mem[4'(int'(base) + i)]});
        i_start = 1'b1;
        i_base_addr = base;
        i_len = len;
        @(posedge clk);
        while (!fin) begin
            @(negedge clk);
            cyc++;
            i_start = poke && cyc == 5;
            if (poke && cyc == 5) begin
                i_base_addr = 4'($urandom);
                i_len = 5'($urandom_range(1, 31));
            end
            i_m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom % 2);
            if (cyc == 1) begin
                chk("busy_on", o_busy, 1);
                chk("done_low", o_done, 0);
            end
            if (abort_n > 0 && nb == abort_n) begin
                rst = 1'b0;
                @(negedge clk);
                chk_reset_values();
                rst = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    chk("no_beat_after_rst", o_m_valid, 0);
                end
                fin = 1;
            end else begin
                if (pv && !pr) chk("stall_hold", {o_m_valid, o_m_last, o_m_data}, {1'b1, pd});
                if (o_m_valid && i_m_ready) begin
                    if (exp_q.size() == 0) chk("extra_beat", 1, 0);
                    else chk($sformatf("beat%0d", nb), {o_m_last, o_m_data}, exp_q.pop_front());
                    if (mode == 0 && tim) chk("beat_time", cyc, 4 + nb);
                    nb++;
                    lx = cyc;
                end
                pv = o_m_valid;
                pr = i_m_ready;
                pd = {o_m_last, o_m_data};
                if (o_done) begin
                    chk("done_busy_low", o_busy, 0);
                    chk("done_valid_low", o_m_valid, 0);
                    chk("done_after_last", lx, cyc - 1);
                    chk("beat_count", nb, n);
                    fin = 1;
                end else if (cyc > 400) begin
                    chk("timeout", 0, 1);
                    fin = 1;
                end
            end
        end
    endtask

    task automatic zero_len();
        i_start = 1'b1;
        i_base_addr = 4'($urandom);
        i_len = '0;
        @(negedge clk);
        i_start = 1'b0;
        chk("zl_done", o_done, 1);
        chk("zl_busy", o_busy, 0);
        chk("zl_valid", o_m_valid, 0);
        @(negedge clk);
        chk("zl_done_once", o_done, 0);
        chk("zl_busy2", o_busy, 0);
        chk("zl_valid2", o_m_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0100 + 16'(i);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_values();
        rst = 1'b1;
        @(negedge clk);
        burst(4'd2, 5'd4, 0, 1, 0, 0);
        burst(4'd14, 5'd4, 0, 1, 0, 0);
        burst(4'd0, 5'd16, 1, 0, 0, 0);
        zero_len();
        burst(4'd3, 5'd31, 0, 1, 0, 0);
        burst(4'd7, 5'd8, 0, 1, 0, 2);
        burst(4'd5, 5'd2, 0, 1, 0, 0);
        burst(4'd9, 5'd10, 0, 1, 1, 0);
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        for (int r = 0; r < 8; r++)
            burst(4'($urandom), 5'($urandom_range(1, 31)), 2, 0, 0, 0);
        burst(4'($urandom), 5'($urandom_range(4, 31)), 0, 1, 1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
